// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: the hex glyph table
// (active-high, bit6 = a ... bit0 = g), the all-off pattern and a polarity helper.
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  localparam logic [SEG_W-1:0] HEX_SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79,
    7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F,
    7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Converts an active-high segment pattern to the board's drive polarity.
  function automatic logic [SEG_W-1:0] applySegPolarity(input logic [SEG_W-1:0] segs,
                                                        input logic activeLow);
    return activeLow ? ~segs : segs;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment glyph lookup (active-high a..g).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       i_nibble,
  output logic [SEG_W-1:0] o_segs
);

  // Straight table lookup; polarity is applied by the caller.
  always_comb begin
    o_segs = HEX_SEG_TABLE[i_nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver. A prescaler paces the digit scan,
// new values are staged in a pending buffer and only swapped into the shadow
// copy at a frame boundary so a frame never shows a mix of old and new digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS       = 8,
  parameter int REFRESH_DIV      = 100000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [NUM_DIGITS-1:0]   Anode_Activate,
  output logic [SEG_W-1:0]        LED_out,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0]      PRE_LAST    = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST    = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF   = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]      SEG_OFF_OUT = applySegPolarity(SEG_OFF, SEG_ACTIVE_LOW);
  localparam logic                  DP_OFF      = SEG_ACTIVE_LOW;

  logic [PRE_W-1:0]        r_prescale;
  logic [IDX_W-1:0]        r_digit;
  logic [4*NUM_DIGITS-1:0] r_pendVal;
  logic [NUM_DIGITS-1:0]   r_pendDp;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_shadowVal;
  logic [NUM_DIGITS-1:0]   r_shadowDp;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [SEG_W-1:0]        r_seg;
  logic                    r_dp;
  logic                    r_frameDone;

  logic                    w_tick;
  logic                    w_boundary;
  logic [NUM_DIGITS-1:0]   w_blankMask;
  logic [NUM_DIGITS-1:0]   w_anodeHot;
  logic [3:0]              w_curNibble;
  logic                    w_curDp;
  logic                    w_digitOn;
  logic [SEG_W-1:0]        w_decSegs;

  assign w_tick      = (r_prescale == PRE_LAST);
  assign w_boundary  = w_tick && (r_digit == IDX_LAST);
  assign w_curNibble = r_shadowVal[4*r_digit +: 4];
  assign w_curDp     = r_shadowDp[r_digit];
  assign w_digitOn   = enable && !w_blankMask[r_digit];

  // Prescaler: one tick every REFRESH_DIV cycles sets the per-digit slot length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prescale <= '0;
    end else if (w_tick) begin
      r_prescale <= '0;
    end else begin
      r_prescale <= r_prescale + 1'b1;
    end
  end

  // Scan index: advances on each tick, wrapping after the last digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digit <= '0;
    end else if (w_tick) begin
      if (r_digit == IDX_LAST) begin
        r_digit <= '0;
      end else begin
        r_digit <= r_digit + 1'b1;
      end
    end
  end

  // Capture: loads stage in pending and commit at the frame boundary; a load
  // landing exactly on the boundary goes straight to the shadow copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pendVal   <= '0;
      r_pendDp    <= '0;
      r_pending   <= 1'b0;
      r_shadowVal <= '0;
      r_shadowDp  <= '0;
    end else if (load && w_boundary) begin
      r_shadowVal <= value_in;
      r_shadowDp  <= dp_in;
      r_pending   <= 1'b0;
    end else if (w_boundary && r_pending) begin
      r_shadowVal <= r_pendVal;
      r_shadowDp  <= r_pendDp;
      r_pending   <= 1'b0;
    end else if (load) begin
      r_pendVal <= value_in;
      r_pendDp  <= dp_in;
      r_pending <= 1'b1;
    end
  end

  // Leading-zero mask: digit i is blanked when it and every higher nibble is zero.
  always_comb begin : blankScan
    logic zeroRun;
    w_blankMask = '0;
    zeroRun     = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zeroRun        = zeroRun && (r_shadowVal[4*i +: 4] == 4'h0);
      w_blankMask[i] = blank_lz && zeroRun;
    end
  end

  // One-hot digit select in active-high form, polarity applied at the register.
  always_comb begin
    w_anodeHot          = '0;
    w_anodeHot[r_digit] = 1'b1;
  end

  seg7_hex_decode u_hexDecode (
    .i_nibble (w_curNibble),
    .o_segs   (w_decSegs)
  );

  // Output register: drives the current digit, or all-off when disabled/blanked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_anode     <= ANODE_OFF;
      r_seg       <= SEG_OFF_OUT;
      r_dp        <= DP_OFF;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_boundary;
      if (w_digitOn) begin
        r_anode <= ANODE_ACTIVE_LOW ? ~w_anodeHot : w_anodeHot;
        r_seg   <= applySegPolarity(w_decSegs, SEG_ACTIVE_LOW);
        r_dp    <= w_curDp ^ SEG_ACTIVE_LOW;
      end else begin
        r_anode <= ANODE_OFF;
        r_seg   <= SEG_OFF_OUT;
        r_dp    <= DP_OFF;
      end
    end
  end

  assign Anode_Activate = r_anode;
  assign LED_out        = r_seg;
  assign dp_out         = r_dp;
  assign frame_done     = r_frameDone;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed seven-segment display driver for the board display of the pipelined RISC-V top level.
- Takes a packed hex value plus per-digit decimal points and scans NUM_DIGITS common-anode digits with a programmable refresh rate.
- Adds features the fixed 8-digit display path lacks: frame-synchronous value update (no tearing), leading-zero blanking, global enable, selectable output polarity and a frame-done pulse.

Parameters:
- NUM_DIGITS, 8, digits scanned; legal range 1..16.
- REFRESH_DIV, 100000, clk cycles each digit stays active; must be >= 2.
- ANODE_ACTIVE_LOW, 1, 1 = anode asserted by driving 0.
- SEG_ACTIVE_LOW, 1, 1 = segment lit by driving 0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- value_in  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, digit 0 is rightmost
- dp_in  in  NUM_DIGITS  per-digit decimal point, active-high
- load  in  1  request to capture value_in and dp_in
- blank_lz  in  1  leading-zero suppression enable
- enable  in  1  display enable
- Anode_Activate  out  NUM_DIGITS  one-hot digit select at the configured polarity
- LED_out  out  7  segments; bit6 = a ... bit0 = g
- dp_out  out  1  decimal-point segment at SEG polarity
- frame_done  out  1  one-cycle pulse when the last digit's slot ends

Behaviour:
- Reset (rst low, asynchronous): prescaler = 0, digit index = 0, shadow value/dp = 0, pending flag = 0. Anode_Activate all inactive, LED_out all segments off, dp_out off, frame_done = 0.
- Prescaler: counts 0..REFRESH_DIV-1 and is $clog2(REFRESH_DIV) bits wide. tick = (count == REFRESH_DIV-1); the count wraps to 0 on tick.
- Digit index: increments on tick and wraps NUM_DIGITS-1 -> 0. The wrap cycle is the frame boundary. frame_done is registered and asserted for the single cycle after the boundary tick.
- Capture: load latches value_in and dp_in into the pending registers and sets pending.
  - At a frame boundary with pending set, pending copies to the shadow and pending clears.
  - load on the boundary cycle itself bypasses pending and commits directly to the shadow.
  - A second load before the boundary overwrites pending; the last load wins.
- Display source is always the shadow, so a frame never mixes old and new values.
- Outputs are registered and update 1 cycle after the digit index changes. Each digit is active for exactly REFRESH_DIV cycles, and exactly one anode is active at a time unless blanked.
- Hex decode (active-high a..g before polarity): 0 7E, 1 30, 2 6D, 3 79, 4 33, 5 5B, 6 5F, 7 70, 8 7F, 9 7B, A 77, b 1F, C 4E, d 3D, E 4F, F 47. Active-low output is the bitwise inverse.
- Leading-zero blanking: digit i (i > 0) is blanked when blank_lz = 1 and nibbles i..NUM_DIGITS-1 of the shadow are all zero. Digit 0 is never blanked.
  - A blanked digit keeps its anode inactive, segments off and dp off for its full time slot; scan timing is unchanged.
- enable = 0: anodes inactive and segments/dp off within 1 cycle. Prescaler, index and capture keep running, and frame_done still pulses.
- Reset mid-frame: outputs go inactive immediately without a clock edge, and any pending load is discarded.

Decomposition:
- Package seg7_pkg: 16-entry hex-to-segment constant table (active-high a..g), SEG_OFF constant, and a function applying polarity.
- Sub-module seg7_hex_decode: combinational 4-bit -> 7-bit lookup using the package table.
- Prescaler, scan index, capture and blanking logic stay in seg7_scan_driver.

Test Plan (NUM_DIGITS=8, REFRESH_DIV=4, both polarities active-low):
- Reset held, then released -> Anode_Activate = 8'hFF, LED_out = 7'h7F, dp_out = 1, frame_done = 0; with enable = 1 and no load after release, first frame shows "0" (7'b0000001) on every digit in sequence.
- Load 32'h0123ABCD, dp_in = 8'h01, wait one frame boundary.
  - Next frame: Anode 8'hFE with LED_out 7'b1000010 ("d") and dp_out = 0.
  - Then 8'hFD with 7'b0110001 ("C"), ... then 8'h7F with 7'b0000001 ("0").
- blank_lz = 1, load 32'h00000050 -> digits 7..2 never activate an anode; digit 1 shows 7'b0100100 ("5") and digit 0 shows 7'b0000001. Load 0 -> only digit 0 is lit.
- Load 32'h11111111 during digit 3 of a frame that displays 32'h22222222 -> digits 3..7 still show "2" (7'b0010010); "1" (7'b1001111) appears from digit 0 of the next frame.
- Timing: each anode stays low exactly 4 cycles; frame_done pulses every 32 cycles, one cycle wide. Load on a boundary cycle is shown in the immediately following frame.
- Assert rst asynchronously mid-slot -> Anode = 8'hFF same timestep; after release, pending load is lost and display shows 0. enable = 0 -> Anode = 8'hFF next cycle while frame_done continues every 32 cycles.
